rr_encoder_4_2: RTL and testbench
=================================

Name: rr_encoder_4_2

Overview:
- Registered 4-request round-robin encoder that drives the 2-bit code and enable into the 2-4 decoder stage directly downstream.
- Arbitrates four request lines and presents the index of the granted line on Encoded_Value_Out with Valid_Out.
- Holds the grant until the requester drops, Release_In is pulsed, or a hold timeout expires.
- Inserts one idle cycle between grants so the decoder never sees back-to-back code changes.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles Valid_Out stays high for one grant. 0 disables the timeout.
- COUNT_WIDTH, 8, width of the hold counter. HOLD_MAX must be less than 2^COUNT_WIDTH.

Ports:
- Clock_In  input  1  single clock; all state updates on its rising edge.
- Reset_N_In  input  1  reset, synchronous, active-low.
- Request_In  input  4  request lines; bit i requests code i.
- Release_In  input  1  one-cycle pulse; ends the current grant.
- Encoded_Value_Out  output  2  index of the granted requester, to the decoder's encoded input.
- Valid_Out  output  1  high while Encoded_Value_Out holds a live grant.
- Timeout_Out  output  1  one-cycle pulse when a grant is ended by the timeout.

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset, when Reset_N_In is low at a rising edge:
  - state=IDLE, Encoded_Value_Out=2'b00, Valid_Out=0, Timeout_Out=0.
  - Round-robin pointer Ptr=0, hold counter=0.
  - Reset overrides all other activity, including mid-grant: Valid_Out goes low after that edge.
- State IDLE (Valid_Out=0):
  - If Request_In!=0 at an edge, select the first set bit searching Ptr, Ptr+1, ... mod 4.
  - After that edge: Encoded_Value_Out=selected index, Valid_Out=1, counter=0, state=GRANT.
  - Latency from a sampled request to Valid_Out is 1 cycle.
  - If Request_In=0, stay in IDLE. Encoded_Value_Out holds its last value.
- State GRANT (Valid_Out=1, index g): evaluate at each edge, in priority order:
  - a) Release_In=1 → exit, Timeout_Out=0.
  - b) Request_In[g]=0 → exit, Timeout_Out=0.
  - c) HOLD_MAX!=0 and counter==HOLD_MAX-1 → exit, Timeout_Out=1 for exactly one cycle.
  - d) otherwise → stay, counter+1.
- On exit:
  - state=IDLE, Valid_Out=0, Ptr=(g+1) mod 4. Wrap from 3 to 0.
  - Encoded_Value_Out keeps g during the idle cycle.
- The earliest next grant is the edge after the exit edge, so there is always at least one Valid_Out=0 cycle between grants.
- A grant lasts at most HOLD_MAX Valid_Out-high cycles.
- Release_In and Request_In changes while in IDLE do not affect the pointer. Release_In in IDLE is ignored.
- Simultaneous release and timeout: release wins, and Timeout_Out stays 0.
- A lone persistent requester is re-granted after the idle cycle; starvation-freedom comes from the Ptr rotation.
- The counter saturates logically: it never increments past HOLD_MAX-1. With HOLD_MAX=0 it stays at 0.

Test Plan:
1. Reset priority:
   - Stimulus: Reset_N_In=0 for 3 edges with Request_In=4'b1111, then release reset.
   - Required: Valid_Out=0 and Encoded_Value_Out=00 during reset; first grant index 0, Valid_Out high 1 cycle after reset release.
2. Rotation:
   - Stimulus: Request_In=4'b1111 held, Release_In pulsed on the 2nd cycle of each grant.
   - Required: codes 0,1,2,3,0 with exactly one Valid_Out=0 cycle between grants.
3. Drop and wrap:
   - Stimulus: Request_In=4'b0100 → grant 2; then Request_In=4'b0001.
   - Required: Valid_Out low the cycle after the drop; next grant is code 0, searched from Ptr=3 and wrapping.
4. Timeout, HOLD_MAX=4:
   - Stimulus: Request_In=4'b1000 held.
   - Required: Valid_Out high exactly 4 cycles with code 3; Timeout_Out pulses once on the exit edge; one idle cycle; code 3 re-granted.
5. Simultaneous events:
   - Stimulus: Release_In=1 on the edge where counter==HOLD_MAX-1.
   - Required: exit with Timeout_Out=0.
6. Reset mid-grant:
   - Stimulus: Reset_N_In=0 while granting code 2.
   - Required: Valid_Out=0 after that edge; after reset with Request_In=4'b0110, grant code 1 (Ptr restarted at 0).

Source files
------------

// File: rtl/rr_encoder_4_2.sv
// Registered 4-request round-robin encoder feeding a downstream 2-4 decoder.
// Grants are held until the requester drops, Release_In pulses, or the hold
// timeout expires. There is always one idle cycle between grants, so the
// decoder never sees back-to-back code changes.
module rr_encoder_4_2 #(
    parameter int unsigned HOLD_MAX    = 8,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic       Clock_In,
    input  logic       Reset_N_In,
    input  logic [3:0] Request_In,
    input  logic       Release_In,
    output logic [1:0] Encoded_Value_Out,
    output logic       Valid_Out,
    output logic       Timeout_Out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Counter value on the last permitted Valid_Out-high cycle of a grant.
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? '0 : COUNT_WIDTH'(HOLD_MAX - 1);
    localparam logic TIMEOUT_EN = (HOLD_MAX != 0);

    logic [0:0]             state;
    logic [1:0]             ptr;
    logic [COUNT_WIDTH-1:0] hold_cnt;

    logic                   sel_found;
    logic [1:0]             sel_idx;
    logic [1:0]             cand;
    logic                   grant_drop;
    logic                   timeout_hit;

    // Round-robin search: first set request starting at ptr, wrapping mod 4.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!sel_found && Request_In[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Grant exit conditions, evaluated against the currently granted index.
    always_comb begin
        grant_drop  = Release_In || !Request_In[Encoded_Value_Out];
        timeout_hit = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
    end

    // Grant FSM, pointer rotation, hold counter and registered outputs.
    always_ff @(posedge Clock_In) begin
        if (!Reset_N_In) begin
            state             <= ST_IDLE;
            ptr               <= 2'd0;
            hold_cnt          <= '0;
            Encoded_Value_Out <= 2'b00;
            Valid_Out         <= 1'b0;
            Timeout_Out       <= 1'b0;
        end else begin
            Timeout_Out <= 1'b0;
            if (state == ST_IDLE) begin
                if (sel_found) begin
                    state             <= ST_GRANT;
                    Encoded_Value_Out <= sel_idx;
                    Valid_Out         <= 1'b1;
                    hold_cnt          <= '0;
                end
            end else begin
                // Release/drop outrank the timeout, so Timeout_Out only
                // fires when the grant would otherwise have continued.
                if (grant_drop || timeout_hit) begin
                    state       <= ST_IDLE;
                    Valid_Out   <= 1'b0;
                    ptr         <= Encoded_Value_Out + 2'd1;
                    Timeout_Out <= !grant_drop;
                end else if (TIMEOUT_EN) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_encoder_4_2.sv
// Self-checking bench for rr_encoder_4_2 (HOLD_MAX=4): directed scenarios
// followed by randomized traffic, all compared against a behavioural model.
module tb_rr_encoder_4_2;

    localparam int unsigned HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [1:0] code;
    logic       valid;
    logic       tmo;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model state: grant status, granted index, number of
    // Valid-high cycles the current grant has had, rotation start point.
    bit          m_valid;
    int unsigned m_code;
    int unsigned m_held;
    int unsigned m_ptr;
    bit          m_tmo;

    rr_encoder_4_2 #(
        .HOLD_MAX   (HOLD),
        .COUNT_WIDTH(8)
    ) dut (
        .Clock_In         (clk),
        .Reset_N_In       (rst_n),
        .Request_In       (req),
        .Release_In       (rel),
        .Encoded_Value_Out(code),
        .Valid_Out        (valid),
        .Timeout_Out      (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_edge(input bit r_n, input logic [3:0] rq, input bit rl);
        if (!r_n) begin
            m_valid = 0; m_code = 0; m_held = 0; m_ptr = 0; m_tmo = 0;
        end else if (!m_valid) begin
            m_tmo = 0;
            for (int unsigned k = 0; k < 4; k++) begin
                if (!m_valid && rq[(m_ptr + k) % 4]) begin
                    m_valid = 1;
                    m_code  = (m_ptr + k) % 4;
                    m_held  = 1;
                end
            end
        end else begin
            m_tmo = 0;
            if (rl || !rq[m_code]) begin
                m_valid = 0;
                m_ptr   = (m_code + 1) % 4;
            end else if (HOLD != 0 && m_held == HOLD) begin
                m_valid = 0;
                m_ptr   = (m_code + 1) % 4;
                m_tmo   = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Drive inputs away from the edge, clock once, then compare outputs.
    task automatic step(input bit r_n, input logic [3:0] rq, input bit rl);
        @(negedge clk);
        rst_n = r_n;
        req   = rq;
        rel   = rl;
        @(posedge clk);
        model_edge(r_n, rq, rl);
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        check("code", 32'(code), 32'(m_code));
        check("timeout", 32'(tmo), 32'(m_tmo));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_valid = 0; m_code = 0; m_held = 0; m_ptr = 0; m_tmo = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        rel   = 1'b0;

        // Reset priority: requests asserted during reset are ignored.
        repeat (3) step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        check("first_grant_code", 32'(code), 32'd0);
        check("first_grant_valid", 32'(valid), 32'd1);

        // Rotation: release on the 2nd cycle of each grant.
        step(1'b1, 4'b1111, 1'b1);
        for (int g = 1; g <= 4; g++) begin
            check("rot_idle", 32'(valid), 32'd0);
            step(1'b1, 4'b1111, 1'b0);
            check("rot_code", 32'(code), 32'(g % 4));
            step(1'b1, 4'b1111, 1'b1);
        end

        // Drop and wrap: grant 2, drop it, then only request 0.
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("drop_valid", 32'(valid), 32'd0);
        step(1'b1, 4'b0001, 1'b0);
        check("wrap_code", 32'(code), 32'd0);
        step(1'b1, 4'b0000, 1'b0);

        // Timeout: lone persistent requester 3.
        step(1'b1, 4'b1000, 1'b0);
        repeat (3) step(1'b1, 4'b1000, 1'b0);
        check("to_still_valid", 32'(valid), 32'd1);
        step(1'b1, 4'b1000, 1'b0);
        check("to_pulse", 32'(tmo), 32'd1);
        step(1'b1, 4'b1000, 1'b0);
        check("to_regrant", 32'(code), 32'd3);
        check("to_pulse_once", 32'(tmo), 32'd0);

        // Release on the timeout edge: release wins, no timeout pulse.
        repeat (3) step(1'b1, 4'b1000, 1'b0);
        step(1'b1, 4'b1000, 1'b1);
        check("rel_vs_to_tmo", 32'(tmo), 32'd0);
        check("rel_vs_to_valid", 32'(valid), 32'd0);

        // Reset mid-grant on code 2, then pointer restarts at 0.
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        step(1'b1, 4'b0110, 1'b0);
        check("rst_ptr_code", 32'(code), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
                 ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
